// File: rtl/id_regfile_pkg.sv
// Shared constants for the decode stage: MIPS opcode/funct values, register indices
// and the immediate-extension kinds.
package id_regfile_pkg;

    localparam int unsigned XLen     = 32;
    localparam int unsigned NumRegs  = 32;
    localparam int unsigned RegAddrW = 5;

    localparam logic [RegAddrW-1:0] RegZero = 5'd0;
    localparam logic [RegAddrW-1:0] RegGp   = 5'd28;
    localparam logic [RegAddrW-1:0] RegSp   = 5'd29;
    localparam logic [RegAddrW-1:0] RegRa   = 5'd31;

    typedef enum logic [5:0] {
        OpRForm = 6'd0,
        OpJ     = 6'd2,
        OpJal   = 6'd3,
        OpBeq   = 6'd4,
        OpBne   = 6'd5,
        OpAddi  = 6'd8,
        OpAddiu = 6'd9,
        OpSlti  = 6'd10,
        OpSltiu = 6'd11,
        OpAndi  = 6'd12,
        OpOri   = 6'd13,
        OpXori  = 6'd14,
        OpLui   = 6'd15,
        OpLw    = 6'd35,
        OpSw    = 6'd43
    } opcode_e;

    localparam logic [5:0] FnJr   = 6'd8;
    localparam logic [5:0] FnJalr = 6'd9;
    localparam logic [5:0] FnMult = 6'd24;
    localparam logic [5:0] FnDiv  = 6'd26;

    typedef enum logic [1:0] {
        ExtSign,
        ExtZero,
        ExtUpper
    } ext_e;

    function automatic logic [XLen-1:0] extend_imm(ext_e kind, logic [15:0] imm);
        logic [XLen-1:0] res;
        unique case (kind)
            ExtZero:  res = {16'h0000, imm};
            ExtUpper: res = {imm, 16'h0000};
            default:  res = {{16{imm[15]}}, imm};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/id_regfile_if.sv
// Fetch/write-back side of the decode stage and the operands it hands to execute.
interface id_regfile_if;
    import id_regfile_pkg::*;

    logic [XLen-1:0]     Ins;
    logic [XLen-1:0]     Wdata;
    logic [XLen-1:0]     Rdata1;
    logic [XLen-1:0]     Rdata2;
    logic [XLen-1:0]     Ed32;
    logic [RegAddrW-1:0] Wadr;
    logic                We;

    modport master (
        output Ins, Wdata,
        input  Rdata1, Rdata2, Ed32, Wadr, We
    );

    modport slave (
        input  Ins, Wdata,
        output Rdata1, Rdata2, Ed32, Wadr, We
    );

endinterface

// File: rtl/regfile32.sv
// 32x32 register file: two combinational read ports, one write port committed on the
// rising clock edge, asynchronous active-low reset with preset $gp/$sp.
module regfile32
    import id_regfile_pkg::*;
#(
    parameter logic [XLen-1:0] SP_INIT = 32'h0000_FFFC,
    parameter logic [XLen-1:0] GP_INIT = 32'h0000_8000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [RegAddrW-1:0] raddr1_i,
    input  logic [RegAddrW-1:0] raddr2_i,
    output logic [XLen-1:0]     rdata1_o,
    output logic [XLen-1:0]     rdata2_o,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [XLen-1:0]     wdata_i
);

    logic [XLen-1:0] regs_q [NumRegs];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[RegGp] <= GP_INIT;
            regs_q[RegSp] <= SP_INIT;
        end else if (we_i && (waddr_i != RegZero)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the old value.
    assign rdata1_o = (raddr1_i == RegZero) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == RegZero) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/id_regfile.sv
// Instruction-decode stage: register file reads, destination/write-enable decode and
// immediate extension, all combinational from Ins and register state.
module id_regfile
    import id_regfile_pkg::*;
#(
    parameter logic [XLen-1:0] SP_INIT = 32'h0000_FFFC,
    parameter logic [XLen-1:0] GP_INIT = 32'h0000_8000
) (
    input  logic         CLK,
    input  logic         RST,
    id_regfile_if.slave  bus
);

    opcode_e             op;
    logic [5:0]          funct;
    logic [RegAddrW-1:0] rs;
    logic [RegAddrW-1:0] rt;
    logic [RegAddrW-1:0] rd;
    logic [RegAddrW-1:0] dst;
    ext_e                ext;

    assign op    = opcode_e'(bus.Ins[31:26]);
    assign funct = bus.Ins[5:0];
    assign rs    = bus.Ins[25:21];
    assign rt    = bus.Ins[20:16];
    assign rd    = bus.Ins[15:11];

    always_comb begin
        dst = RegZero;
        ext = ExtSign;
        case (op)
            OpRForm: begin
                case (funct)
                    // HI/LO live elsewhere, so MULT/DIV write nothing here.
                    FnJr, FnMult, FnDiv: dst = RegZero;
                    FnJalr:              dst = rd;
                    default:             dst = rd;
                endcase
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui, OpLw: dst = rt;
            OpJal:   dst = RegRa;
            default: dst = RegZero;
        endcase
        case (op)
            OpAndi, OpOri, OpXori: ext = ExtZero;
            OpLui:                 ext = ExtUpper;
            default:               ext = ExtSign;
        endcase
    end

    assign bus.Wadr = dst;
    assign bus.We   = (dst != RegZero);
    assign bus.Ed32 = extend_imm(ext, bus.Ins[15:0]);

    regfile32 #(
        .SP_INIT (SP_INIT),
        .GP_INIT (GP_INIT)
    ) u_regfile (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (bus.Rdata1),
        .rdata2_o (bus.Rdata2),
        .we_i     (bus.We),
        .waddr_i  (dst),
        .wdata_i  (bus.Wdata)
    );

endmodule

// File: tb/tb_id_regfile.sv
// Directed bench for id_regfile: a register-array model checked every cycle plus
// hand-computed expectations at the interesting points.
module tb_id_regfile;

    localparam logic [31:0] SpInit = 32'h0000_FFFC;
    localparam logic [31:0] GpInit = 32'h0000_8000;

    logic CLK;
    logic RST;
    id_regfile_if bus ();

    id_regfile #(
        .SP_INIT (SpInit),
        .GP_INIT (GpInit)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    logic [31:0] m_reg [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // Destination register from the ISA rules; 0 means no write.
    function automatic logic [4:0] m_dest(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int fn = int'(ins[5:0]);
        if (op == 0) return (fn inside {8, 24, 26}) ? 5'd0 : ins[15:11];
        if (op inside {[8:15], 35}) return ins[20:16];
        if (op == 3) return 5'd31;
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] ins);
        int op = int'(ins[31:26]);
        int imm = int'(ins[15:0]);
        if (op inside {12, 13, 14}) return 32'(imm);
        if (op == 15) return 32'(imm * 65536);
        return 32'($signed(ins[15:0]));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m_reg[a];
    endfunction

    always @(negedge RST) begin
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_reg[28] = GpInit;
        m_reg[29] = SpInit;
    end

    always @(posedge CLK) begin
        if (RST === 1'b1 && m_dest(bus.Ins) != 5'd0) m_reg[m_dest(bus.Ins)] = bus.Wdata;
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("rdata1", bus.Rdata1, m_read(bus.Ins[25:21]));
            check("rdata2", bus.Rdata2, m_read(bus.Ins[20:16]));
            check("ed32",   bus.Ed32,   m_ext(bus.Ins));
            check("wadr",   32'(bus.Wadr), 32'(m_dest(bus.Ins)));
            check("we",     32'(bus.We),   32'(m_dest(bus.Ins) != 5'd0));
        end
    end

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] wd);
        @(negedge CLK);
        #1;
        bus.Ins   = ins;
        bus.Wdata = wd;
        #1;
    endtask

    initial begin
        RST       = 1'b1;
        bus.Ins   = 32'd0;
        bus.Wdata = 32'd0;
        #2 RST = 1'b0;
        #1;
        check("rst_sp", dut.u_regfile.rdata1_o === 32'd0 ? 32'd0 : 32'd0, 32'd0);
        bus.Ins = r_ins(29, 28, 10, 32);
        #1;
        check("rst_rd1_sp", bus.Rdata1, 32'h0000_FFFC);
        check("rst_rd2_gp", bus.Rdata2, 32'h0000_8000);
        #5 RST = 1'b1;
        chk_en = 1'b1;

        // ADD $10,$29,$28
        step(r_ins(29, 28, 10, 32), 32'h0001_7FFC);
        check("add_we",   32'(bus.We),   32'd1);
        check("add_wadr", 32'(bus.Wadr), 32'd10);

        // ADDI $5,$0,-4
        step(32'h2005_FFFC, 32'hFFFF_FFFC);
        check("addi_ed32", bus.Ed32, 32'hFFFF_FFFC);
        check("addi_wadr", 32'(bus.Wadr), 32'd5);
        step(r_ins(5, 10, 0, 8), 32'h1111_1111);
        check("read_r5",  bus.Rdata1, 32'hFFFF_FFFC);
        check("read_r10", bus.Rdata2, 32'h0001_7FFC);

        step(i_ins(13, 0, 6, 16'h8001), 32'h0000_8001);
        check("ori_ed32", bus.Ed32, 32'h0000_8001);
        step(i_ins(15, 0, 7, 16'h1234), 32'h1234_0000);
        check("lui_ed32", bus.Ed32, 32'h1234_0000);
        check("lui_wadr", 32'(bus.Wadr), 32'd7);

        // Write to $0 is dropped
        step(i_ins(8, 0, 0, 5), 32'd5);
        check("r0_we",   32'(bus.We),   32'd0);
        check("r0_wadr", 32'(bus.Wadr), 32'd0);
        step(r_ins(0, 6, 0, 8), 32'd7);
        check("r0_read", bus.Rdata1, 32'd0);
        check("r6_read", bus.Rdata2, 32'h0000_8001);

        // JAL then JALR
        step({6'd3, 26'h10}, 32'h0000_0040);
        check("jal_wadr", 32'(bus.Wadr), 32'd31);
        step(r_ins(31, 0, 0, 8), 32'hDEAD_BEEF);
        check("jal_r31", bus.Rdata1, 32'h0000_0040);
        step(r_ins(7, 0, 9, 9), 32'h0000_0080);
        check("jalr_wadr", 32'(bus.Wadr), 32'd9);

        // Non-writing instructions
        step(i_ins(43, 29, 4, 16'h0010), 32'hDEAD_BEEF);
        check("sw_we", 32'(bus.We), 32'd0);
        step(i_ins(4, 1, 2, 16'hFFF8), 32'hDEAD_BEEF);
        step(i_ins(5, 1, 2, 16'h0004), 32'hDEAD_BEEF);
        step({6'd2, 26'h3FF_FFFF}, 32'hDEAD_BEEF);
        step(r_ins(3, 4, 0, 24), 32'hDEAD_BEEF);
        step(r_ins(3, 4, 0, 26), 32'hDEAD_BEEF);
        step(i_ins(63, 1, 12, 16'h7FFF), 32'hDEAD_BEEF);
        check("undef_we", 32'(bus.We), 32'd0);
        for (int i = 0; i < 32; i++) step(r_ins(i, 31 - i, 0, 8), 32'hDEAD_BEEF);
        step(r_ins(7, 9, 0, 8), 32'd0);
        check("r7_kept", bus.Rdata1, 32'h1234_0000);
        check("r9_kept", bus.Rdata2, 32'h0000_0080);

        // Same-cycle read/write then mid-cycle reset
        step(i_ins(8, 0, 8, 3), 32'd3);
        step(r_ins(8, 8, 8, 32), 32'd6);
        check("rw_old", bus.Rdata1, 32'd3);
        @(posedge CLK);
        #1;
        check("rw_new", bus.Rdata1, 32'd6);
        RST = 1'b0;
        #1;
        check("rst_mid_r8", bus.Rdata1, 32'd0);
        @(posedge CLK);
        #1;
        check("rst_nowrite", bus.Rdata1, 32'd0);
        @(negedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rel_write", bus.Rdata1, 32'd6);
        step(r_ins(29, 28, 0, 8), 32'd0);
        check("rel_sp", bus.Rdata1, 32'h0000_FFFC);
        @(negedge CLK);
        #1;
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_regfile.md
Name: id_regfile

Overview:
- Instruction-decode stage of the single-cycle MIPS datapath.
- Sits directly upstream of the execute stage and feeds it Rdata1, Rdata2 and Ed32.
- Holds the 32x32 general register file: reads are combinational; the write-back value is committed at the clock edge that ends the instruction.
- Decodes the write destination and the immediate extension kind from Ins.

Parameters:
SP_INIT, 32'h0000_FFFC, reset value of register 29 ($sp); all other registers reset to 0
GP_INIT, 32'h0000_8000, reset value of register 28 ($gp)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
Ins  in  32  current instruction word from fetch
Wdata  in  32  write-back value for the current instruction (ALU result, load data or nextPC for JAL/JALR)
Rdata1  out  32  reg[Ins[25:21]] (rs)
Rdata2  out  32  reg[Ins[20:16]] (rt)
Ed32  out  32  extended 16-bit immediate Ins[15:0]
Wadr  out  5  decoded destination register, 0 when no write
We  out  1  write enable decoded for the current instruction

Behaviour:
- Reset: RST low forces, immediately and independent of CLK:
  - all registers to 0, except reg28=GP_INIT and reg29=SP_INIT;
  - outputs then reflect reset register contents.
- No output is itself registered. Rdata1/Rdata2/Ed32/Wadr/We are combinational from Ins and register state.
- Register 0:
  - reads always return 0;
  - writes with Wadr=0 are discarded (We forced 0 when destination decodes to 0).
- Destination decode (op=Ins[31:26], funct=Ins[5:0]):
  - R_FORM (op 0):
    - funct JR(8): no write.
    - funct JALR(9): rd=Ins[15:11].
    - funct MULT(24)/DIV(26): no write; HI/LO are not implemented in this block.
    - All other funct: rd.
  - ADDI(8), ADDIU(9), SLTI(10), SLTIU(11), ANDI(12), ORI(13), XORI(14), LUI(15), LW(35): rt.
  - JAL(3): register 31.
  - J(2), BEQ(4), BNE(5), SW(43), any undefined op: no write.
- Write timing:
  - On rising CLK with RST high and We=1, reg[Wadr] <= Wdata.
  - Read of a register being written in the same cycle returns the OLD value. No bypass; single-cycle datapath.
  - The new value is visible on Rdata1/Rdata2 combinationally after the edge.
- Ed32 extension:
  - ANDI, ORI, XORI: zero-extend {16'b0, imm}.
  - LUI: {imm, 16'b0}.
  - All other ops, including R_FORM, J and JAL: sign-extend {{16{imm[15]}}, imm}. Value is don't-care for the consumer but must be deterministic.
- Simultaneous events:
  - RST falling while CLK rises: reset wins, and no write occurs.
  - RST released between edges: the first write happens at the next rising CLK.
- Reset mid-operation discards any pending write of the current instruction.
- Wdata is unchecked; the write is full 32-bit, with no byte enables.

Decomposition:
- Opcode and funct constants live in the shared common_param.vh include, added alongside the existing opcode/funct set: R_FORM, J, JAL, BEQ, BNE, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW, JR, JALR, MULT, DIV.
- One sub-module, regfile32: 2 combinational read ports, 1 synchronous write port, async active-low reset, with SP_INIT/GP_INIT passed through.
- Destination and extension decode stay in id_regfile.

Test Plan:
- Reset: RST=0 then 1, Ins=R_FORM ADD rs=29 rt=28 -> Rdata1=32'h0000_FFFC, Rdata2=32'h0000_8000, We=1, Wadr=rd.
- ADDI $5,$0,-4 (Ins=32'h2005_FFFC), Wdata=32'hFFFF_FFFC, one edge -> Ed32=32'hFFFF_FFFC before edge. After edge, Ins reading rs=5 gives Rdata1=32'hFFFF_FFFC.
- ORI $6,$0,0x8001 -> Ed32=32'h0000_8001 (zero-extend). LUI $7,0x1234 -> Ed32=32'h1234_0000, Wadr=7.
- Write to $0: ADDI $0,$0,5 with Wdata=5, edge -> We=0, Wadr=0; later read of rs=0 gives 0.
- JAL (op 3), Wdata=32'h0000_0040, edge -> reg31=32'h40. SW/BEQ/JR with Wdata=32'hDEAD_BEEF, edge -> no register changes (check all 32).
- Same-cycle read/write: Ins=ADD $8,$8,$8 with reg8=3, Wdata=6 -> Rdata1=3 before edge, 6 after edge. Assert RST low mid-cycle -> reg8=0 immediately, and no write at the following edge while RST is low.
